// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped responder with reload timer/irq, LED and 7-seg registers,
// free-running systick and an 8N1 UART transmitter.
module peripheral_bus #(
    parameter int          BAUD_DIV = 10417,
    parameter logic [31:0] BASE     = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        irq,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        uart_tx
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [5:0] A_TH = 6'h00, A_TL = 6'h01, A_TCON = 6'h02, A_LED = 6'h03,
                           A_DIGI = 6'h04, A_SYS = 6'h05, A_TXD = 6'h06, A_CON = 6'h08;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state;
    logic [31:0]   r_th, r_tl, r_systick;
    logic [2:0]    r_tcon;
    logic [7:0]    r_led, r_txd;
    logic [11:0]   r_digi;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic          r_tx, r_done;
    logic          w_hit, w_wr, w_rd_con, w_bit_end, w_tl_max;
    logic [5:0]    w_reg;

    assign w_hit     = Address[31:8] == BASE[31:8];
    assign w_reg     = Address[7:2];
    assign w_wr      = MemWrite && w_hit;
    assign w_rd_con  = MemRead && w_hit && w_reg == A_CON;
    assign w_bit_end = r_cnt == CW'(BAUD_DIV - 1);
    assign w_tl_max  = &r_tl;

    assign irq     = r_tcon[2];
    assign led     = r_led;
    assign digi    = r_digi;
    assign uart_tx = r_tx;

    // CPU writes to TL/TCON take priority over the timer's own update on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th      <= '0;
            r_tl      <= '0;
            r_tcon    <= '0;
            r_led     <= '0;
            r_digi    <= '0;
            r_systick <= '0;
        end else begin
            if (w_wr && w_reg == A_TH) r_th <= Write_data;
            if (w_wr && w_reg == A_TL) r_tl <= Write_data;
            else if (r_tcon[0]) r_tl <= w_tl_max ? r_th : r_tl + 32'd1;
            if (w_wr && w_reg == A_TCON) r_tcon <= Write_data[2:0];
            else if (r_tcon[0] && r_tcon[1] && w_tl_max) r_tcon[2] <= 1'b1;
            if (w_wr && w_reg == A_LED) r_led <= Write_data[7:0];
            if (w_wr && w_reg == A_DIGI) r_digi <= Write_data[11:0];
            r_systick <= r_systick + 32'd1;
        end
    end

    // tx_done clear is assigned first so a coincident end-of-frame set wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_txd   <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            if (w_rd_con) r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_wr && w_reg == A_TXD) begin
                    r_txd   <= Write_data[7:0];
                    r_cnt   <= '0;
                    r_tx    <= 1'b0;
                    r_state <= START;
                end
                START: if (w_bit_end) begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_tx    <= r_txd[0];
                    r_state <= DATA;
                end else r_cnt <= r_cnt + 1'b1;
                DATA: if (w_bit_end) begin
                    r_cnt   <= '0;
                    r_idx   <= r_idx + 3'd1;
                    r_tx    <= r_idx == 3'd7 ? 1'b1 : r_txd[r_idx + 3'd1];
                    r_state <= r_idx == 3'd7 ? STOP : DATA;
                end else r_cnt <= r_cnt + 1'b1;
                STOP: if (w_bit_end) begin
                    r_cnt   <= '0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end else r_cnt <= r_cnt + 1'b1;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        Read_data = '0;
        if (MemRead && w_hit)
            case (w_reg)
                A_TH:    Read_data = r_th;
                A_TL:    Read_data = r_tl;
                A_TCON:  Read_data = {29'd0, r_tcon};
                A_LED:   Read_data = {24'd0, r_led};
                A_DIGI:  Read_data = {20'd0, r_digi};
                A_SYS:   Read_data = r_systick;
                A_CON:   Read_data = {27'd0, r_state != IDLE, 1'b0, r_done, 2'd0};
                default: Read_data = '0;
            endcase
    end
endmodule
